// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Groups the pipeline request/response handshake and the word-wide data
//   memory bus of the load/store unit into one bundle.
//
//   Handshake: a request is taken on a rising clk edge where req_valid and
//   req_ready are both high. req_ready is high only while the unit is idle,
//   so the requester must hold req_valid and the request fields until that
//   edge; req_valid seen while req_ready is low is ignored. Completion is a
//   single-cycle done pulse; err and rdata are meaningful with done.
//
//   Modports:
//     slave  - the load/store unit (takes requests, drives the memory bus)
//     master - the environment (pipeline driving requests, memory returning
//              mem_rdata)
//
//   Signals:
//     req_valid, req_op[2:0], req_addr[31:0], req_wdata[31:0]  request
//     req_ready, busy, done, err, rdata[31:0]                  response
//     mem_read, mem_write, mem_adr[31:0], mem_wdata[31:0]       memory command
//     mem_rdata[31:0]                                          memory read data
interface load_store_unit_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
        output req_ready, busy, done, err, rdata,
               mem_read, mem_write, mem_adr, mem_wdata
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_rdata,
        input  req_ready, busy, done, err, rdata,
               mem_read, mem_write, mem_adr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   MEM-stage access unit. Turns byte/halfword/word loads and stores into
//   word-only transactions on a memory whose read data is combinational and
//   whose write commits on the clock edge while mem_write is high.
//   Sub-word stores are done as read-modify-write; loads are sign- or
//   zero-extended into a held rdata register.
//
//   Parameters:
//     ERR_ON_MISALIGN  1: misaligned request completes with err and no access
//                      0: low address bits are cleared and the access proceeds
//     BIG_ENDIAN       0: byte 0 is word bits [7:0]; 1: byte 0 is bits [31:24]
//
//   Ports:
//     clk        clock
//     rst        asynchronous active-high reset
//     bus        load_store_unit_if.slave (request, response and memory bus)
//     state_dbg  current FSM state (0 IDLE, 1 RD, 2 WR, 3 RESP)
//
//   Flow: IDLE -> RD -> RESP (loads), IDLE -> RD -> WR -> RESP (SB/SH),
//         IDLE -> WR -> RESP (SW), IDLE -> RESP (misaligned, err).
module load_store_unit #(
    parameter bit ERR_ON_MISALIGN = 1'b1,
    parameter bit BIG_ENDIAN      = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus,
    output logic [1:0]       state_dbg
);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_SW  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_SB  = 3'b110;
    localparam logic [2:0] OP_SH  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  op_q;
    // Only the in-word byte offset is kept; the word address lives in mem_adr.
    logic [1:0]  lane_q;
    // Only SB/SH need the store data after the request cycle.
    logic [15:0] wdata_q;

    // ------------------------------------------------------------------
    // Request decode, used only in IDLE
    // ------------------------------------------------------------------
    logic        req_is_word;
    logic        req_is_half;
    logic        req_misaligned;
    logic [31:0] req_addr_aligned;

    always_comb begin
        req_is_word = (bus.req_op == OP_LW) || (bus.req_op == OP_SW);
        req_is_half = (bus.req_op == OP_LH) || (bus.req_op == OP_LHU) ||
                      (bus.req_op == OP_SH);
        req_misaligned = (req_is_word && (bus.req_addr[1:0] != 2'b00)) ||
                         (req_is_half && bus.req_addr[0]);
        // Clearing the low bits is harmless for aligned requests, and is the
        // defined behaviour for misaligned ones when errors are disabled.
        req_addr_aligned = bus.req_addr;
        if (req_is_word) begin
            req_addr_aligned[1:0] = 2'b00;
        end else if (req_is_half) begin
            req_addr_aligned[0] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Lane extraction and sub-word merge against the word being read in RD
    // ------------------------------------------------------------------
    logic [1:0]  byte_sel;
    logic        half_sel;
    logic [4:0]  byte_shamt;
    logic [4:0]  half_shamt;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] byte_mask;
    logic [31:0] half_mask;
    logic [31:0] load_ext;
    logic [31:0] merged_word;
    logic        op_is_load;

    always_comb begin
        // Big-endian lane n sits where little-endian lane (3-n) would.
        byte_sel   = BIG_ENDIAN ? ~lane_q : lane_q;
        half_sel   = BIG_ENDIAN ? ~lane_q[1] : lane_q[1];
        byte_shamt = {byte_sel, 3'b000};
        half_shamt = {half_sel, 4'b0000};

        rd_byte = 8'(bus.mem_rdata >> byte_shamt);
        rd_half = 16'(bus.mem_rdata >> half_shamt);

        byte_mask = 32'h0000_00FF << byte_shamt;
        half_mask = 32'h0000_FFFF << half_shamt;

        case (op_q)
            OP_LB:   load_ext = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  load_ext = {24'h0, rd_byte};
            OP_LH:   load_ext = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_ext = {16'h0, rd_half};
            default: load_ext = bus.mem_rdata;
        endcase

        if (op_q == OP_SH) begin
            merged_word = (bus.mem_rdata & ~half_mask) |
                          ({16'h0, wdata_q} << half_shamt);
        end else begin
            merged_word = (bus.mem_rdata & ~byte_mask) |
                          ({24'h0, wdata_q[7:0]} << byte_shamt);
        end

        op_is_load = (op_q != OP_SW) && (op_q != OP_SB) && (op_q != OP_SH);
    end

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            op_q          <= OP_LB;
            lane_q        <= 2'b00;
            wdata_q       <= 16'h0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.rdata     <= 32'h0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_adr   <= 32'h0;
            bus.mem_wdata <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.done <= 1'b0;
                    bus.err  <= 1'b0;
                    if (bus.req_valid) begin
                        op_q    <= bus.req_op;
                        lane_q  <= req_addr_aligned[1:0];
                        wdata_q <= bus.req_wdata[15:0];
                        if (ERR_ON_MISALIGN && req_misaligned) begin
                            // No memory access at all; report straight away.
                            state     <= S_RESP;
                            bus.done  <= 1'b1;
                            bus.err   <= 1'b1;
                            bus.rdata <= 32'h0;
                        end else if (bus.req_op == OP_SW) begin
                            state         <= S_WR;
                            bus.mem_adr   <= {req_addr_aligned[31:2], 2'b00};
                            bus.mem_write <= 1'b1;
                            bus.mem_wdata <= bus.req_wdata;
                        end else begin
                            state        <= S_RD;
                            bus.mem_adr  <= {req_addr_aligned[31:2], 2'b00};
                            bus.mem_read <= 1'b1;
                        end
                    end
                end

                S_RD: begin
                    bus.mem_read <= 1'b0;
                    if (op_is_load) begin
                        state     <= S_RESP;
                        bus.rdata <= load_ext;
                        bus.done  <= 1'b1;
                        bus.err   <= 1'b0;
                    end else begin
                        // SB/SH: write back the read word with the new lane.
                        state         <= S_WR;
                        bus.mem_write <= 1'b1;
                        bus.mem_wdata <= merged_word;
                    end
                end

                S_WR: begin
                    state         <= S_RESP;
                    bus.mem_write <= 1'b0;
                    bus.mem_wdata <= 32'h0;
                    bus.done      <= 1'b1;
                    bus.err       <= 1'b0;
                end

                S_RESP: begin
                    state    <= S_IDLE;
                    bus.done <= 1'b0;
                    bus.err  <= 1'b0;
                end

                default: begin
                    state         <= S_IDLE;
                    bus.done      <= 1'b0;
                    bus.err       <= 1'b0;
                    bus.mem_read  <= 1'b0;
                    bus.mem_write <= 1'b0;
                    bus.mem_wdata <= 32'h0;
                end
            endcase
        end
    end

    assign bus.req_ready = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign state_dbg     = state;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side memory access unit for the MIPS pipeline's MEM stage. It sits between the pipeline and the word-addressed data memory.
- It converts byte, halfword and word load/store requests into word-only memory transactions on the memory's mem_read/mem_write/adr/write_data/read_data interface.
- Sub-word stores are performed as read-modify-write. Loads are sign- or zero-extended.
- busy is used by the hazard unit to stall the pipeline.

Parameters:
ERR_ON_MISALIGN, 1, 1: misaligned request returns err with no memory access; 0: low address bits are forced to alignment and the access proceeds.
BIG_ENDIAN, 0, 0: byte at addr[1:0]=0 is word bits [7:0]; 1: byte at addr[1:0]=0 is bits [31:24].

Ports:
clk  input  1  clock
rst  input  1  reset
req_valid  input  1  request strobe; sampled only in IDLE
req_op  input  3  000 LB, 001 LH, 010 LW, 011 SW, 100 LBU, 101 LHU, 110 SB, 111 SH
req_addr  input  32  byte address
req_wdata  input  32  store data; SB uses [7:0], SH uses [15:0]
req_ready  output  1  high in IDLE
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle completion pulse
err  output  1  misalignment flag; valid with done
rdata  output  32  extended load data; valid with done, held until next done
mem_read  output  1  to data memory
mem_write  output  1  to data memory
mem_adr  output  32  word-aligned address {addr[31:2],2'b00}
mem_wdata  output  32  store word
mem_rdata  input  32  combinational read data from memory

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - On reset: state=IDLE; done=0, err=0, rdata=0, mem_read=0, mem_write=0, mem_adr=0, mem_wdata=0.
  - Reset mid-operation abandons the access immediately. No further mem_write is issued. A write already clocked into memory stands.
- Memory model: read data is valid combinationally in the same cycle mem_read and mem_adr are driven. A write commits on the posedge while mem_write=1.
- States: IDLE, RD, WR, RESP.
- IDLE, req_valid=1: latch op, addr and wdata.
  - Misaligned and ERR_ON_MISALIGN=1 -> RESP with err=1. Misaligned means: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0.
  - LW, LB, LH, LBU, LHU, SB, SH -> RD.
  - SW -> WR.
- RD: mem_read=1 for exactly this cycle.
  - Capture mem_rdata.
  - Loads: extract the lane and extend into the rdata register -> RESP.
  - SB/SH: merge wdata into the captured word at the addressed lane -> WR.
- WR: mem_write=1 for exactly this cycle; mem_wdata = merged word (SW: latched wdata) -> RESP.
- RESP: done=1 for one cycle.
  - err=1 only for a misaligned request; in that case rdata=0.
  - Stores leave rdata unchanged.
  - -> IDLE.
- mem_read and mem_write are decoded from the state, are never both high, and are 0 in IDLE and RESP.
- mem_adr is held stable through RD and WR. mem_wdata is 0 outside WR.
- Latency from the accept edge, where T is the cycle req_valid is sampled in IDLE: loads and SW give done at T+2; SB/SH give done at T+3; misaligned gives done at T+1.
- req_valid outside IDLE is ignored. No queueing. Back-to-back requests are accepted the cycle after RESP.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend. Lane select is by addr[1:0] (byte) or addr[1] (half), per BIG_ENDIAN.
- With ERR_ON_MISALIGN=0, addr is masked (LW/SW bits[1:0], halfword bit[0]) and err is never set.

Test Plan:
1. Memory word 0x10 = 0x8899AABB. LB addr 0x11 -> exactly one mem_read, mem_adr=0x10; done at T+2, rdata=0xFFFFFFAA, err=0.
2. Same word, LHU addr 0x12 -> rdata=0x00008899. LH addr 0x12 -> rdata=0xFFFF8899.
3. SB addr 0x13, wdata 0x12345677 -> RD at T+1, WR at T+2 with mem_wdata=0x7799AABB; done at T+3; word 0x10 then reads 0x7799AABB. SW addr 0x14, wdata 0xDEADBEEF -> no mem_read, single mem_write at T+1, done at T+2.
4. LW addr 0x12 and SH addr 0x11 -> done at T+1 with err=1, rdata=0; mem_read and mem_write stay 0.
5. req_valid held high for 6 cycles with alternating LW 0x10 / LW 0x14 -> only the requests sampled in IDLE are accepted, one every 3 cycles; busy and req_ready are complementary throughout.
6. Assert rst asynchronously while in WR of an SB -> mem_write drops immediately, all outputs reach reset values, and the memory word is unchanged. The next LW after reset completes normally.
